// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between NREQ
// requesters. The operands driving the ALU are registered, and the ALU result
// and flags are captured into a response register under a valid/ready
// handshake.
// Optional build macro ALU_ARB_LOCK_EN adds a req_lock input. An accepted
// locked request pins the following grants to the same requester.
module alu_arbiter #(
  parameter int NREQ   = 2,
  parameter int WORD_W = 32,
  parameter int OP_W   = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [OP_W*NREQ-1:0]     req_op,
  input  logic [WORD_W*NREQ-1:0]   req_porta,
  input  logic [WORD_W*NREQ-1:0]   req_portb,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]          req_lock,
`endif
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WORD_W-1:0]        rsp_out,
  output logic                     rsp_zf,
  output logic                     rsp_nf,
  output logic                     rsp_of,
  output logic [OP_W-1:0]          alu_op,
  output logic [WORD_W-1:0]        alu_porta,
  output logic [WORD_W-1:0]        alu_portb,
  input  logic [WORD_W-1:0]        alu_out,
  input  logic                     alu_zf,
  input  logic                     alu_nf,
  input  logic                     alu_of
);

  localparam int          ID_W = $clog2(NREQ);
  localparam int unsigned NR   = NREQ;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nx;
  logic [ID_W-1:0]   rr_ptr;
  logic              grant_any;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   idx;
  logic              accept;

  logic [OP_W-1:0]   op_arr [NREQ];
  logic [WORD_W-1:0] a_arr  [NREQ];
  logic [WORD_W-1:0] b_arr  [NREQ];

`ifdef ALU_ARB_LOCK_EN
  logic              lock_active;
  logic [ID_W-1:0]   lock_owner;
`endif

  // Unpack the flat per-requester buses into indexable arrays.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g] = req_op[g*OP_W +: OP_W];
    assign a_arr[g]  = req_porta[g*WORD_W +: WORD_W];
    assign b_arr[g]  = req_portb[g*WORD_W +: WORD_W];
  end

  // Round-robin winner search starting just after the last granted requester.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      idx = ID_W'((32'(rr_ptr) + k) % NR);
`ifdef ALU_ARB_LOCK_EN
      if (!grant_any && req_valid[idx] && (!lock_active || idx == lock_owner)) begin
`else
      if (!grant_any && req_valid[idx]) begin
`endif
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  assign accept = (state == IDLE) && grant_any;

  // One-hot grant, only offered while idle.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand, response, pointer and lock registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr      <= ID_W'(NREQ - 1);
      alu_op      <= '0;
      alu_porta   <= '0;
      alu_portb   <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_out     <= '0;
      rsp_zf      <= 1'b0;
      rsp_nf      <= 1'b0;
      rsp_of      <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      lock_active <= 1'b0;
      lock_owner  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          alu_op    <= op_arr[grant_id];
          alu_porta <= a_arr[grant_id];
          alu_portb <= b_arr[grant_id];
          rsp_id    <= grant_id;
          rr_ptr    <= grant_id;
`ifdef ALU_ARB_LOCK_EN
          // While locked only the owner can win, so the winner's lock bit
          // alone decides whether the lock is set, kept or released.
          lock_active <= req_lock[grant_id];
          lock_owner  <= grant_id;
`endif
        end
        EXEC: begin
          rsp_out   <= alu_out;
          rsp_zf    <= alu_zf;
          rsp_nf    <= alu_nf;
          rsp_of    <= alu_of;
          rsp_valid <= 1'b1;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
